apb_bridge_ctrl: RTL and testbench

Sequences the APB side of the AHB2APB bridge. It takes AHB transfers on the AHB slave side (Hwrite/Htrans/Haddr/Hwdata/Hreadyin) and converts them into APB SETUP/ENABLE phases. It drives Hreadyout to stall the AHB master while an APB access completes, and returns Prdata as Hrdata. It supports single and back-to-back (pipelined) reads and writes to 3 APB slaves.

---
 rtl/apb_bridge_pkg.sv | 26 ++
 rtl/ahb_slave_if.sv | 67 ++++++
 rtl/apb_bridge_ctrl.sv | 167 ++++++++++++++++
 tb/tb_apb_bridge_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge controller.
package apb_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_READ,
      ST_WRITE,
      ST_WRITEP,
      ST_RENABLE,
      ST_WENABLE,
      ST_WENABLEP
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY = 2'b00;

   localparam int unsigned NUM_SLV_DEF   = 3;
   localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;
   localparam logic [31:0] SLV_SIZE_DEF  = 32'h0400_0000;

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-side front end: address/data pipeline registers, transfer qualification
// and one-hot slave decode for the current and the two delayed addresses.
module ahb_slave_if
   import apb_bridge_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       NUM_SLV   = NUM_SLV_DEF,
   parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter logic [ADDR_W-1:0] SLV_SIZE  = SLV_SIZE_DEF
) (
   input  logic               Hclk,
   input  logic               Hresetn,
   input  logic               Hwrite,
   input  logic [1:0]         Htrans,
   input  logic [ADDR_W-1:0]  Haddr,
   input  logic [DATA_W-1:0]  Hwdata,
   input  logic               Hreadyin,
   output logic               valid,
   output logic [ADDR_W-1:0]  Haddr1,
   output logic [ADDR_W-1:0]  Haddr2,
   output logic [DATA_W-1:0]  Hwdata1,
   output logic               Hwritereg,
   output logic [NUM_SLV-1:0] sel_now,
   output logic [NUM_SLV-1:0] sel_d1,
   output logic [NUM_SLV-1:0] sel_d2
);

   localparam logic [ADDR_W:0] BASE_W = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] SLV_W  = {1'b0, SLV_SIZE};

   // One extra bit makes addresses below the window wrap to a huge offset,
   // so a single range test per slave also rejects them.
   function automatic logic [NUM_SLV-1:0] decode(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W:0] off;
      logic [ADDR_W:0] lo;
      decode = '0;
      off    = {1'b0, addr} - BASE_W;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         lo = (ADDR_W+1)'(i) * SLV_W;
         if (off >= lo && off < lo + SLV_W)
            decode = decode | (NUM_SLV'(1) << i);
      end
   endfunction

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         Haddr1    <= '0;
         Haddr2    <= '0;
         Hwdata1   <= '0;
         Hwritereg <= 1'b0;
      end else begin
         Haddr1    <= Haddr;
         Haddr2    <= Haddr1;
         Hwdata1   <= Hwdata;
         Hwritereg <= Hwrite;
      end
   end

   always_comb begin
      sel_now = decode(Haddr);
      sel_d1  = decode(Haddr1);
      sel_d2  = decode(Haddr2);
      valid   = Hreadyin && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ) && (|sel_now);
   end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// APB sequencer of the AHB2APB bridge: converts qualified AHB transfers into
// APB SETUP/ENABLE phases and stalls the AHB master while they complete.
module apb_bridge_ctrl
   import apb_bridge_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       NUM_SLV   = NUM_SLV_DEF,
   parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter logic [ADDR_W-1:0] SLV_SIZE  = SLV_SIZE_DEF
) (
   input  logic               Hclk,
   input  logic               Hresetn,
   input  logic               Hwrite,
   input  logic [1:0]         Htrans,
   input  logic [ADDR_W-1:0]  Haddr,
   input  logic [DATA_W-1:0]  Hwdata,
   input  logic               Hreadyin,
   output logic               Hreadyout,
   output logic [DATA_W-1:0]  Hrdata,
   output logic [1:0]         Hresp,
   input  logic [DATA_W-1:0]  Prdata,
   output logic [ADDR_W-1:0]  Paddr,
   output logic [DATA_W-1:0]  Pwdata,
   output logic               Pwrite,
   output logic [NUM_SLV-1:0] Pselx,
   output logic               Penable
);

   state_t               state;
   logic                 valid;
   logic                 Hwritereg;
   logic [ADDR_W-1:0]    Haddr1;
   logic [ADDR_W-1:0]    Haddr2;
   logic [DATA_W-1:0]    Hwdata1;
   logic [NUM_SLV-1:0]   sel_now;
   logic [NUM_SLV-1:0]   sel_d1;
   logic [NUM_SLV-1:0]   sel_d2;

   ahb_slave_if #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_SLV  (NUM_SLV),
      .BASE_ADDR(BASE_ADDR),
      .SLV_SIZE (SLV_SIZE)
   ) u_ahb_slave_if (
      .Hclk     (Hclk),
      .Hresetn  (Hresetn),
      .Hwrite   (Hwrite),
      .Htrans   (Htrans),
      .Haddr    (Haddr),
      .Hwdata   (Hwdata),
      .Hreadyin (Hreadyin),
      .valid    (valid),
      .Haddr1   (Haddr1),
      .Haddr2   (Haddr2),
      .Hwdata1  (Hwdata1),
      .Hwritereg(Hwritereg),
      .sel_now  (sel_now),
      .sel_d1   (sel_d1),
      .sel_d2   (sel_d2)
   );

   assign Hrdata = Prdata;
   assign Hresp  = HRESP_OKAY;

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state     <= ST_IDLE;
         Pselx     <= '0;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= '0;
         Pwdata    <= '0;
         Hreadyout <= 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
               if (valid && Hwrite) begin
                  state     <= ST_WWAIT;
                  Pselx     <= '0;
                  Penable   <= 1'b0;
                  Hreadyout <= 1'b1;
               end else if (valid) begin
                  state     <= ST_READ;
                  Paddr     <= Haddr;
                  Pselx     <= sel_now;
                  Pwrite    <= 1'b0;
                  Penable   <= 1'b0;
                  Hreadyout <= 1'b0;
               end else begin
                  state     <= ST_IDLE;
                  Pselx     <= '0;
                  Penable   <= 1'b0;
                  Hreadyout <= 1'b1;
               end
            end
            // Write data arrives one cycle after its address, so the SETUP
            // phase uses the once-delayed address with the live data bus.
            ST_WWAIT: begin
               Paddr   <= Haddr1;
               Pwdata  <= Hwdata;
               Pselx   <= sel_d1;
               Pwrite  <= 1'b1;
               Penable <= 1'b0;
               if (valid) begin
                  state     <= ST_WRITEP;
                  Hreadyout <= 1'b0;
               end else begin
                  state     <= ST_WRITE;
                  Hreadyout <= 1'b1;
               end
            end
            ST_READ: begin
               state     <= ST_RENABLE;
               Penable   <= 1'b1;
               Hreadyout <= 1'b1;
            end
            ST_WRITE: begin
               Penable <= 1'b1;
               if (valid) begin
                  state     <= ST_WENABLEP;
                  Hreadyout <= 1'b0;
               end else begin
                  state     <= ST_WENABLE;
                  Hreadyout <= 1'b1;
               end
            end
            ST_WRITEP: begin
               state     <= ST_WENABLEP;
               Penable   <= 1'b1;
               Hreadyout <= 1'b0;
            end
            // The stalled follow-on write sits two stages back in the pipeline.
            ST_WENABLEP: begin
               Penable <= 1'b0;
               if (Hwritereg) begin
                  Paddr  <= Haddr2;
                  Pwdata <= Hwdata1;
                  Pselx  <= sel_d2;
                  Pwrite <= 1'b1;
                  if (valid) begin
                     state     <= ST_WRITEP;
                     Hreadyout <= 1'b0;
                  end else begin
                     state     <= ST_WRITE;
                     Hreadyout <= 1'b1;
                  end
               end else begin
                  state     <= ST_READ;
                  Paddr     <= Haddr;
                  Pselx     <= sel_now;
                  Pwrite    <= 1'b0;
                  Hreadyout <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               Pselx     <= '0;
               Penable   <= 1'b0;
               Hreadyout <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed bench for apb_bridge_ctrl: per-cycle handshake table, a
// transaction-level APB access scoreboard and a few literal pins.
module tb_apb_bridge_ctrl;
   import apb_bridge_pkg::*;

   localparam logic [1:0] TI = HTRANS_IDLE;
   localparam logic [1:0] TB = HTRANS_BUSY;
   localparam logic [1:0] TN = HTRANS_NONSEQ;
   localparam logic [1:0] TS = HTRANS_SEQ;

   localparam longint unsigned M_BASE = 64'h8000_0000;
   localparam longint unsigned M_SIZE = 64'h0400_0000;
   localparam longint unsigned M_NSLV = 3;

   logic        Hclk = 1'b0;
   logic        Hresetn = 1'b0;
   logic        Hwrite = 1'b0;
   logic [1:0]  Htrans = HTRANS_IDLE;
   logic [31:0] Haddr = '0;
   logic [31:0] Hwdata = '0;
   logic        Hreadyin = 1'b1;
   logic        Hreadyout;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;
   logic [31:0] Prdata = '0;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic        Pwrite;
   logic [2:0]  Pselx;
   logic        Penable;

   always #5 Hclk = ~Hclk;

   apb_bridge_ctrl #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .NUM_SLV  (3),
      .BASE_ADDR(32'h8000_0000),
      .SLV_SIZE (32'h0400_0000)
   ) dut (
      .Hclk     (Hclk),
      .Hresetn  (Hresetn),
      .Hwrite   (Hwrite),
      .Htrans   (Htrans),
      .Haddr    (Haddr),
      .Hwdata   (Hwdata),
      .Hreadyin (Hreadyin),
      .Hreadyout(Hreadyout),
      .Hrdata   (Hrdata),
      .Hresp    (Hresp),
      .Prdata   (Prdata),
      .Paddr    (Paddr),
      .Pwdata   (Pwdata),
      .Pwrite   (Pwrite),
      .Pselx    (Pselx),
      .Penable  (Penable)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  tr;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        rin;
      logic [31:0] prd;
      logic [2:0]  e_sel;
      logic        e_en;
      logic        e_rdy;
      int          pin;
   } row_t;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  sel;
      logic [31:0] data;
   } acc_t;

   row_t tbl[$];
   acc_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cur = 0;
   logic running = 1'b0;

   logic        last_v = 1'b0;
   logic [31:0] last_addr;
   logic [2:0]  last_sel;
   logic        last_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s row=%0d actual=%h required=%h", name, cur, act, req);
      end
   endtask

   task automatic add(input logic rst, input logic [1:0] tr, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd, input logic rin,
                      input logic [31:0] prd, input logic [2:0] sel, input logic en,
                      input logic rdy, input int pin);
      tbl.push_back('{rst, tr, wr, addr, wd, rin, prd, sel, en, rdy, pin});
   endtask

   // Address map model: slave index from plain window arithmetic, -1 if outside.
   function automatic int slave_of(input logic [31:0] addr);
      longint unsigned a = longint'(addr);
      if (a >= M_BASE && a < M_BASE + M_NSLV * M_SIZE)
         return int'((a - M_BASE) / M_SIZE);
      return -1;
   endfunction

   // Rows: inputs for the cycle, then the select/enable/ready seen in it.
   task automatic build();
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 4);
      add(0, TN, 1, 32'h8000_0004, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TI, 1, 32'h0,         32'hDEAD_BEEF, 1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b001, 0, 1, 1);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b001, 1, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 0, 32'h8400_0010, 32'h0,         1, 32'h1234_5678, 3'b000, 0, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h1234_5678, 3'b010, 0, 0, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h1234_5678, 3'b010, 1, 1, 2);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 1, 32'h8800_0000, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TS, 1, 32'h8800_0004, 32'h11,        1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TI, 1, 32'h0,         32'h22,        1, 32'h0,         3'b100, 0, 0, 5);
      add(0, TI, 1, 32'h0,         32'h22,        1, 32'h0,         3'b100, 1, 0, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b100, 0, 1, 6);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b100, 1, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 1, 32'h8000_0008, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 0, 32'h8000_000C, 32'hA5A5_0008, 1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 0, 32'h8000_000C, 32'hA5A5_0008, 1, 32'hCAFE_F00D, 3'b001, 0, 0, 0);
      add(0, TN, 0, 32'h8000_000C, 32'hA5A5_0008, 1, 32'hCAFE_F00D, 3'b001, 1, 0, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'hCAFE_F00D, 3'b001, 0, 0, 3);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'hCAFE_F00D, 3'b001, 1, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 0, 32'h9000_0000, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TB, 0, 32'h8000_0000, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 0, 32'h8000_0000, 32'h0,         0, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 1, 32'h8C00_0000, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 0, 32'h7FFF_FFFC, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 0, 32'h8BFF_FFFC, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b100, 0, 0, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b100, 1, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TN, 1, 32'h8400_0000, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TI, 1, 32'h0,         32'h55,        1, 32'h0,         3'b000, 0, 1, 0);
      add(1, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 4);
      add(0, TN, 0, 32'h8000_0020, 32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0BAD_CAFE, 3'b001, 0, 0, 0);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0BAD_CAFE, 3'b001, 1, 1, 7);
      add(0, TI, 0, 32'h0,         32'h0,         1, 32'h0,         3'b000, 0, 1, 0);
   endtask

   initial begin
      build();
      repeat (3) @(posedge Hclk);
      #1 Hresetn = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge Hclk);
         #1;
         Hresetn  = !tbl[i].rst;
         Htrans   = tbl[i].tr;
         Hwrite   = tbl[i].wr;
         Haddr    = tbl[i].addr;
         Hwdata   = tbl[i].wd;
         Hreadyin = tbl[i].rin;
         Prdata   = tbl[i].prd;
         cur      = i;
         running  = 1'b1;
         // A transfer is taken when qualified while the bus is ready; write
         // data follows on the next cycle.
         if (tbl[i].rst) begin
            exp_q.delete();
         end else if (tbl[i].rin && tbl[i].tr[1] && tbl[i].e_rdy && slave_of(tbl[i].addr) >= 0) begin
            acc_t a;
            a.addr = tbl[i].addr;
            a.wr   = tbl[i].wr;
            a.sel  = 3'b001 << slave_of(tbl[i].addr);
            a.data = (tbl[i].wr && i + 1 < tbl.size()) ? tbl[i+1].wd : 32'h0;
            exp_q.push_back(a);
         end
      end
      @(posedge Hclk);
      running = 1'b0;
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   always @(negedge Hclk) begin
      if (running) begin
         chk("pselx", Pselx, tbl[cur].e_sel);
         chk("penable", Penable, tbl[cur].e_en);
         chk("hreadyout", Hreadyout, tbl[cur].e_rdy);
         chk("hresp", Hresp, HRESP_OKAY);
         chk("hrdata", Hrdata, Prdata);
         if (Pselx != 3'b000 && !Penable) begin
            chk("setup_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               acc_t e;
               e = exp_q.pop_front();
               chk("setup_paddr", Paddr, e.addr);
               chk("setup_pwrite", Pwrite, e.wr);
               chk("setup_pselx", Pselx, e.sel);
               if (e.wr) chk("setup_pwdata", Pwdata, e.data);
            end
            last_v    = 1'b1;
            last_addr = Paddr;
            last_sel  = Pselx;
            last_wr   = Pwrite;
         end else if (Penable) begin
            chk("enable_has_sel", Pselx != 3'b000, 1);
            chk("enable_after_setup", last_v, 1);
            chk("enable_paddr_hold", Paddr, last_addr);
            chk("enable_pselx_hold", Pselx, last_sel);
            chk("enable_pwrite_hold", Pwrite, last_wr);
            last_v = 1'b0;
         end else begin
            last_v = 1'b0;
         end
         case (tbl[cur].pin)
            1: begin
               chk("pin_wr_addr", Paddr, 32'h8000_0004);
               chk("pin_wr_data", Pwdata, 32'hDEAD_BEEF);
               chk("pin_wr_dir", Pwrite, 1);
            end
            2: chk("pin_rd_data", Hrdata, 32'h1234_5678);
            3: begin
               chk("pin_wr_rd_addr", Paddr, 32'h8000_000C);
               chk("pin_wr_rd_dir", Pwrite, 0);
            end
            4: begin
               chk("pin_rst_paddr", Paddr, 32'h0);
               chk("pin_rst_pwdata", Pwdata, 32'h0);
               chk("pin_rst_pwrite", Pwrite, 0);
            end
            5: begin
               chk("pin_b2b0_addr", Paddr, 32'h8800_0000);
               chk("pin_b2b0_data", Pwdata, 32'h11);
            end
            6: begin
               chk("pin_b2b1_addr", Paddr, 32'h8800_0004);
               chk("pin_b2b1_data", Pwdata, 32'h22);
            end
            7: chk("pin_post_rst_rd", Hrdata, 32'h0BAD_CAFE);
            default: ;
         endcase
      end
   end

endmodule
